// File: rtl/echo_tester_pkg.sv
// ============================================================================
// echo_tester_pkg : shared types, constants and LFSR step for the echo tester
// Rev 1.0
// ============================================================================
`default_nettype none

package echo_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam int unsigned C_DATA_W = 8;
  localparam int unsigned C_CNT_W  = 8;
  localparam int unsigned C_TMO_W  = 24;

  // x^8+x^6+x^5+x^4+1 : feedback taps on bits 7,5,4,3
  localparam logic [C_DATA_W-1:0] C_LFSR_TAPS = 8'hB8;

  localparam int unsigned          C_DEF_NUM_BYTES   = 16;
  localparam logic [C_DATA_W-1:0]  C_DEF_SEED        = 8'hA5;
  localparam logic [C_TMO_W-1:0]   C_DEF_TIMEOUT_CYC = 24'd2_000_000;

  function automatic logic [C_DATA_W-1:0] lfsr_next(input logic [C_DATA_W-1:0] v);
    return {v[C_DATA_W-2:0], ^(v & C_LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/echo_tester_lfsr8.sv
// ============================================================================
// lfsr8 : 8-bit left-shifting Fibonacci LFSR with synchronous load and enable
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr8
  import echo_tester_pkg::*;
#(
  parameter logic [C_DATA_W-1:0] RST_VAL = C_DEF_SEED
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [C_DATA_W-1:0] seed_i,
  output logic [C_DATA_W-1:0] value_o
);

  logic [C_DATA_W-1:0] value_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= RST_VAL;
    end else if (load_i) begin
      value_q <= seed_i;
    end else if (en_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/echo_tester.sv
// ============================================================================
// echo_tester : sends an LFSR byte sequence over the RS-232 echo path and
// scores the returned bytes. Optional macro: ECHO_PARITY_CHECK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module echo_tester
  import echo_tester_pkg::*;
#(
  parameter int unsigned          NUM_BYTES   = C_DEF_NUM_BYTES,
  parameter logic [C_DATA_W-1:0]  SEED        = C_DEF_SEED,
  parameter logic [C_TMO_W-1:0]   TIMEOUT_CYC = C_DEF_TIMEOUT_CYC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                eot_i,
  input  logic                eor_i,
  input  logic [C_DATA_W-1:0] rx_data_i,
  input  logic                pcheck_i,
  output logic                sttx_o,
  output logic [C_DATA_W-1:0] tx_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [C_CNT_W-1:0]  err_cnt_o,
  output logic [C_CNT_W-1:0]  byte_cnt_o
);

  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(NUM_BYTES);

  state_e               state_q;
  logic                 sttx_q;
  logic [C_DATA_W-1:0]  tx_data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [C_CNT_W-1:0]   err_cnt_q;
  logic [C_CNT_W-1:0]   byte_cnt_q;
  logic                 tx_seen_q;
  logic                 rx_seen_q;
  logic                 timeout_q;
  logic [C_DATA_W-1:0]  rx_data_q;
  logic [C_TMO_W-1:0]   tmo_cnt_q;

  logic                 w_start_ok;
  logic                 w_both_seen;
  logic                 w_parity_err;
  logic                 w_err;
  logic [C_CNT_W-1:0]   err_cnt_d;
  logic [C_CNT_W-1:0]   byte_cnt_d;
  logic [C_DATA_W-1:0]  w_lfsr_val;

  assign w_start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Events arriving this cycle count, so both flags set at cycle M reaches CHECK at M+1
  assign w_both_seen = (tx_seen_q || eot_i) && (rx_seen_q || eor_i);

  lfsr8 #(
    .RST_VAL (SEED)
  ) u_lfsr8 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_start_ok),
    .en_i    (state_q == ST_CHECK),
    .seed_i  (SEED),
    .value_o (w_lfsr_val)
  );

`ifdef ECHO_PARITY_CHECK_EN
  logic pchk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pchk_q <= 1'b0;
    end else if (state_q == ST_SEND) begin
      pchk_q <= 1'b0;
    end else if ((state_q == ST_WAIT_ECHO) && eor_i) begin
      pchk_q <= pcheck_i;
    end
  end

  assign w_parity_err = pchk_q;
`else
  logic w_unused_pcheck;
  assign w_unused_pcheck = pcheck_i;
  assign w_parity_err    = 1'b0;
`endif

  assign w_err      = timeout_q || (rx_data_q != tx_data_q) || w_parity_err;
  assign err_cnt_d  = (w_err && (err_cnt_q != {C_CNT_W{1'b1}})) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign byte_cnt_d = byte_cnt_q + 8'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sttx_q     <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_seen_q  <= 1'b0;
      rx_seen_q  <= 1'b0;
      timeout_q  <= 1'b0;
      rx_data_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      sttx_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q    <= ST_SEND;
            sttx_q     <= 1'b1;
            tx_data_q  <= SEED;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            byte_cnt_q <= '0;
          end
        end
        ST_SEND: begin
          tx_seen_q <= 1'b0;
          rx_seen_q <= 1'b0;
          timeout_q <= 1'b0;
          tmo_cnt_q <= '0;
          state_q   <= ST_WAIT_ECHO;
        end
        ST_WAIT_ECHO: begin
          if (eot_i) begin
            tx_seen_q <= 1'b1;
          end
          if (eor_i) begin
            rx_seen_q <= 1'b1;
            rx_data_q <= rx_data_i;
          end
          tmo_cnt_q <= tmo_cnt_q + 24'd1;
          if (w_both_seen) begin
            state_q <= ST_CHECK;
          end else if (tmo_cnt_q == TIMEOUT_CYC - 24'd1) begin
            timeout_q <= 1'b1;
            state_q   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_cnt_q  <= err_cnt_d;
          byte_cnt_q <= byte_cnt_d;
          if (byte_cnt_d == C_LAST_CNT) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end else begin
            // The LFSR steps at this same edge, so present its successor now
            state_q   <= ST_SEND;
            sttx_q    <= 1'b1;
            tx_data_q <= lfsr_next(w_lfsr_val);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sttx_o     = sttx_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_cnt_q;
  assign byte_cnt_o = byte_cnt_q;

endmodule

`default_nettype wire
